// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing CPU and debug accesses to one memory port
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter is loaded at grant and runs down to zero; the capture edge is
  // the one that sees zero, giving the memory WAIT_CYCLES full cycles after
  // the strobe has been registered by it.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    win         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          // Contested: whoever was not granted last time wins.
          win         = (cpu_req && dbg_req) ? ~last_gnt_q : dbg_req;
          owner_d     = win;
          last_gnt_d  = win;
          we_d        = win ? dbg_we : cpu_we;
          mem_addr_d  = win ? dbg_addr : cpu_addr;
          mem_wdata_d = win ? dbg_wdata : cpu_wdata;
          mem_write_d = win ? dbg_we : cpu_we;
          mem_read_d  = win ? ~dbg_we : ~cpu_we;
          cnt_d       = WAIT_LD;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          if (owner_q) begin
            dbg_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic        a_cpu_ack, a_dbg_ack, a_mem_read, a_mem_write, a_busy, a_owner;
  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata;
  logic        b_cpu_ack, b_dbg_ack, b_mem_read, b_mem_write, b_busy, b_owner;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(a_cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(a_dbg_ack),
    .rdata(a_rdata), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(mem_rdata),
    .busy(a_busy), .owner(a_owner)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(b_cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(b_dbg_ack),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(mem_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Exclusivity of acks and strobes, both instances, every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((a_cpu_ack && a_dbg_ack) || (a_mem_read && a_mem_write) ||
          (b_cpu_ack && b_dbg_ack) || (b_mem_read && b_mem_write)) begin
        errors++;
        $display("FAIL exclusive: acks a=%b%b b=%b%b strobes a=%b%b b=%b%b required no pair both high",
                 a_cpu_ack, a_dbg_ack, b_cpu_ack, b_dbg_ack, a_mem_read, a_mem_write, b_mem_read, b_mem_write);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_cpu_ack, a_dbg_ack, a_mem_read, a_mem_write, a_busy, a_owner} !== 6'b0 ||
        a_rdata !== 16'h0 || a_mem_addr !== 16'h0 || a_mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_a: ctl=%b rdata=%h addr=%h wdata=%h required all zero",
               {a_cpu_ack, a_dbg_ack, a_mem_read, a_mem_write, a_busy, a_owner}, a_rdata, a_mem_addr, a_mem_wdata);
    end
    checks++;
    if ({b_cpu_ack, b_dbg_ack, b_mem_read, b_mem_write, b_busy, b_owner} !== 6'b0 ||
        b_rdata !== 16'h0 || b_mem_addr !== 16'h0 || b_mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_b: ctl=%b rdata=%h addr=%h required all zero",
               {b_cpu_ack, b_dbg_ack, b_mem_read, b_mem_write, b_busy, b_owner}, b_rdata, b_mem_addr);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; mem_rdata = 16'hBEEF;
    tick();
    checks++;
    if ({a_mem_read, a_mem_write, a_busy, a_owner, a_cpu_ack} !== 5'b10100 || a_mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL cpu_read_grant: rd,wr,busy,own,ack=%b addr=%h required 10100 addr=0010",
               {a_mem_read, a_mem_write, a_busy, a_owner, a_cpu_ack}, a_mem_addr);
    end
    tick();
    checks++;
    if (a_mem_read !== 1'b0 || a_cpu_ack !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL cpu_read_wait: rd=%b ack=%b busy=%b required 0 0 1", a_mem_read, a_cpu_ack, a_busy);
    end
    tick();
    checks++;
    if (a_cpu_ack !== 1'b1 || a_dbg_ack !== 1'b0 || a_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL cpu_read_ack: ack=%b dbg_ack=%b rdata=%h required 1 0 beef", a_cpu_ack, a_dbg_ack, a_rdata);
    end
    cpu_req = 1'b0;
    mem_rdata = 16'h0000;
    tick();
    checks++;
    if (a_cpu_ack !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL cpu_read_done: ack=%b busy=%b rdata=%h required 0 0 beef", a_cpu_ack, a_busy, a_rdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    dbg_req = 1'b1; dbg_addr = 16'h0002;
    tick();
    checks++;
    if (a_owner !== 1'b0 || a_mem_addr !== 16'h0001) begin
      errors++;
      $display("FAIL contend_first: owner=%b addr=%h required 0 0001", a_owner, a_mem_addr);
    end
    tick(); tick();
    checks++;
    if (a_cpu_ack !== 1'b1 || a_dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL contend_ack1: cpu_ack=%b dbg_ack=%b required 1 0", a_cpu_ack, a_dbg_ack);
    end
    tick(); tick();
    checks++;
    if (a_owner !== 1'b1 || a_mem_addr !== 16'h0002 || a_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL contend_second: owner=%b addr=%h rd=%b required 1 0002 1", a_owner, a_mem_addr, a_mem_read);
    end
    tick(); tick();
    checks++;
    if (a_dbg_ack !== 1'b1 || a_cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL contend_ack2: cpu_ack=%b dbg_ack=%b required 0 1", a_cpu_ack, a_dbg_ack);
    end
    tick(); tick();
    checks++;
    if (a_owner !== 1'b0 || a_mem_addr !== 16'h0001) begin
      errors++;
      $display("FAIL contend_third: owner=%b addr=%h required 0 0001", a_owner, a_mem_addr);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic test_dbg_write();
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h00FF; dbg_wdata = 16'h1234; mem_rdata = 16'h7777;
    tick();
    checks++;
    if ({a_mem_write, a_mem_read, a_owner} !== 3'b101 || a_mem_addr !== 16'h00FF || a_mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL dbg_write_strobe: wr,rd,own=%b addr=%h wdata=%h required 101 00ff 1234",
               {a_mem_write, a_mem_read, a_owner}, a_mem_addr, a_mem_wdata);
    end
    tick();
    checks++;
    if (a_mem_write !== 1'b0 || a_mem_addr !== 16'h00FF || a_mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL dbg_write_pulse: wr=%b addr=%h wdata=%h required 0 00ff 1234", a_mem_write, a_mem_addr, a_mem_wdata);
    end
    tick();
    checks++;
    if (a_dbg_ack !== 1'b1 || a_cpu_ack !== 1'b0 || a_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL dbg_write_ack: dbg_ack=%b cpu_ack=%b rdata=%h required 1 0 0000", a_dbg_ack, a_cpu_ack, a_rdata);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick();
    checks++;
    if (a_dbg_ack !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL dbg_write_done: dbg_ack=%b busy=%b required 0 0", a_dbg_ack, a_busy);
    end
  endtask

  task automatic test_wait3();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; mem_rdata = 16'hCAFE;
    tick();
    checks++;
    if (b_mem_read !== 1'b1 || b_mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL wait3_grant: rd=%b addr=%h required 1 0100", b_mem_read, b_mem_addr);
    end
    cpu_addr = 16'h0200;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (b_cpu_ack !== 1'b0 || b_mem_read !== 1'b0 || b_mem_addr !== 16'h0100 || b_busy !== 1'b1) begin
        errors++;
        $display("FAIL wait3_cycle%0d: ack=%b rd=%b addr=%h busy=%b required 0 0 0100 1",
                 k, b_cpu_ack, b_mem_read, b_mem_addr, b_busy);
      end
    end
    tick();
    checks++;
    if (b_cpu_ack !== 1'b1 || b_rdata !== 16'hCAFE || b_mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL wait3_ack: ack=%b rdata=%h addr=%h required 1 cafe 0100", b_cpu_ack, b_rdata, b_mem_addr);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0033; cpu_wdata = 16'h5555;
    tick();
    checks++;
    if (a_mem_write !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_start: wr=%b busy=%b required 1 1", a_mem_write, a_busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({a_cpu_ack, a_dbg_ack, a_mem_read, a_mem_write, a_busy, a_owner} !== 6'b0 || a_mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_abort: ctl=%b addr=%h required 000000 0000",
               {a_cpu_ack, a_dbg_ack, a_mem_read, a_mem_write, a_busy, a_owner}, a_mem_addr);
    end
    rst = 1'b0; cpu_req = 1'b0;
    tick(); tick();
    checks++;
    if (a_cpu_ack !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_noack: ack=%b busy=%b required 0 0", a_cpu_ack, a_busy);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_dbg_write();
    test_wait3();
    test_rst_mid();
    rst = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
